// File: rtl/queue_ctrl_pkg.sv
// Shared types and constants for the serial word queue controller.
//
// Contents:
//   DATA_W_DEF  default word width (bits per serial word)
//   PAR_BITS    extra serial bits per output burst (1 with parity, else 0)
//   in_state_t  input (assembly) FSM states
//   out_state_t output (serialization) FSM states
//
// Optional feature macro: QUEUE_CTRL_PARITY_EN (adds an even-parity bit
// to the end of every output burst).
package queue_ctrl_pkg;

  localparam int DATA_W_DEF = 8;

`ifdef QUEUE_CTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic {
    COLLECT    = 1'b0,
    WORD_READY = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } out_state_t;

endpackage

// File: rtl/queue_ctrl_if.sv
// Bundle of the serial pins and FIFO-side signals of queue_ctrl.
//
// Strobe semantics (all signals synchronous to the controller clock):
//   write_in, enqueue_in, dequeue_in are single-cycle command pulses that
//   are sampled on one rising edge; there is no back-pressure handshake,
//   a command the controller cannot service is dropped and answered with a
//   one-cycle err_out pulse. fifo_push / fifo_pop are single-cycle strobes
//   to a synchronous FIFO; fifo_rdata is expected one cycle after fifo_pop.
//
// Modports:
//   master - the pin/FIFO environment (drives commands, FIFO flags, rdata)
//   slave  - the controller (drives status, serial output, FIFO strobes,
//            and the two FSM debug state outputs)
interface queue_ctrl_if #(
  parameter int DATA_W = queue_ctrl_pkg::DATA_W_DEF
);
  import queue_ctrl_pkg::*;

  logic              data_in;
  logic              write_in;
  logic              enqueue_in;
  logic              dequeue_in;
  logic              status_out;
  logic              data_out;
  logic              data_valid_out;
  logic              err_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_wdata;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  in_state_t         in_state;
  out_state_t        out_state;

  modport master (
    output data_in, write_in, enqueue_in, dequeue_in,
    output fifo_full, fifo_empty, fifo_rdata,
    input  status_out, data_out, data_valid_out, err_out,
    input  fifo_push, fifo_wdata, fifo_pop,
    input  in_state, out_state
  );

  modport slave (
    input  data_in, write_in, enqueue_in, dequeue_in,
    input  fifo_full, fifo_empty, fifo_rdata,
    output status_out, data_out, data_valid_out, err_out,
    output fifo_push, fifo_wdata, fifo_pop,
    output in_state, out_state
  );

endinterface

// File: rtl/queue_serializer.sv
// Parallel-load, MSB-first serializer for one queue word.
//
// Ports:
//   clock, rst      clock and asynchronous active-low reset
//   load            capture din and start a burst on the next cycle
//   din             word to serialize
//   busy            a burst is in progress
//   last            current cycle carries the final bit of the burst
//   data_out        serial bit (0 when idle)
//   data_valid_out  data_out is valid this cycle
//
// With QUEUE_CTRL_PARITY_EN defined the burst is DATA_W+1 bits, the final
// bit being the XOR of the word (even parity); otherwise DATA_W bits.
module queue_serializer
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              last,
  output logic              data_out,
  output logic              data_valid_out
);

  localparam int SW = DATA_W + PAR_BITS;

  logic [SW-1:0]    sh;
  logic [SW-1:0]    load_val;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;

  // The parity bit simply rides along as the LSB of the shift register.
`ifdef QUEUE_CTRL_PARITY_EN
  assign load_val = {din, ^din};
`else
  assign load_val = din;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sh     <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
    end else if (load) begin
      sh     <= load_val;
      cnt    <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      sh  <= {sh[SW-2:0], 1'b0};
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(SW - 1)) busy_r <= 1'b0;
    end
  end

  assign busy           = busy_r;
  assign last           = busy_r && (cnt == CNT_W'(SW - 1));
  assign data_out       = busy_r & sh[SW-1];
  assign data_valid_out = busy_r;

endmodule

// File: rtl/queue_ctrl.sv
// Sequencing controller between the serial TOP pins and an external
// synchronous word FIFO.
//
// Input path : assembles DATA_W serial bits (first bit -> MSB) and pushes
//              the finished word on enqueue_in.
// Output path: on dequeue_in pops one word and re-serializes it MSB-first;
//              the first valid bit appears 3 cycles after dequeue_in.
//
// Ports:
//   clock  system clock
//   rst    asynchronous active-low reset
//   bus    queue_ctrl_if.slave (serial pins, FIFO strobes/flags, debug
//          FSM states in_state / out_state)
//
// Optional feature macro: QUEUE_CTRL_PARITY_EN (one even-parity bit is
// appended to every output burst by queue_serializer).
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clock,
  input  logic          rst,
  queue_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Input path state
  in_state_t         in_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] word_sr;
  logic              status_r;
  logic              push_r;
  logic [DATA_W-1:0] wdata_r;

  // Output path state
  out_state_t        out_state;
  logic              pop_r;
  logic              err_r;

  // Serializer hookup
  logic              ser_load;
  logic              ser_busy;
  logic              ser_last;
  logic              ser_data;
  logic              ser_valid;

  // Command rejection, evaluated against the current FSM states.
  logic              in_err;
  logic              out_err;

  always_comb begin
    in_err  = 1'b0;
    out_err = 1'b0;
    if (bus.write_in && (in_state != COLLECT))
      in_err = 1'b1;
    if (bus.enqueue_in && ((in_state == COLLECT) || bus.fifo_full))
      in_err = 1'b1;
    if (bus.dequeue_in && ((out_state != IDLE) || bus.fifo_empty))
      out_err = 1'b1;
  end

  // Input FSM: COLLECT shifts bits in, WORD_READY waits for enqueue_in.
  // status_out is registered to track the state the FSM is entering.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      in_state <= COLLECT;
      bit_cnt  <= '0;
      word_sr  <= '0;
      status_r <= 1'b0;
      push_r   <= 1'b0;
      wdata_r  <= '0;
    end else begin
      push_r <= 1'b0;
      case (in_state)
        COLLECT: begin
          status_r <= 1'b1;
          if (bus.write_in) begin
            word_sr <= {word_sr[DATA_W-2:0], bus.data_in};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              in_state <= WORD_READY;
              status_r <= 1'b0;
            end
          end
        end
        WORD_READY: begin
          // A full FIFO leaves the word in place for a later retry.
          if (bus.enqueue_in && !bus.fifo_full) begin
            push_r   <= 1'b1;
            wdata_r  <= word_sr;
            bit_cnt  <= '0;
            in_state <= COLLECT;
            status_r <= 1'b1;
          end
        end
        default: in_state <= COLLECT;
      endcase
    end
  end

  // Output FSM: POP issues the FIFO read, LOAD captures fifo_rdata into
  // the serializer, SHIFT lasts for the serializer burst.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_state <= IDLE;
      pop_r     <= 1'b0;
    end else begin
      pop_r <= 1'b0;
      case (out_state)
        IDLE: begin
          if (bus.dequeue_in && !bus.fifo_empty) begin
            out_state <= POP;
            pop_r     <= 1'b1;
          end
        end
        POP:   out_state <= LOAD;
        LOAD:  out_state <= SHIFT;
        SHIFT: if (ser_last || !ser_busy) out_state <= IDLE;
        default: out_state <= IDLE;
      endcase
    end
  end

  // Both paths feed one registered flag, so simultaneous rejects still
  // produce a single one-cycle pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) err_r <= 1'b0;
    else      err_r <= in_err | out_err;
  end

  assign ser_load = (out_state == LOAD);

  queue_serializer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clock          (clock),
    .rst            (rst),
    .load           (ser_load),
    .din            (bus.fifo_rdata),
    .busy           (ser_busy),
    .last           (ser_last),
    .data_out       (ser_data),
    .data_valid_out (ser_valid)
  );

  assign bus.status_out     = status_r;
  assign bus.fifo_push      = push_r;
  assign bus.fifo_wdata     = wdata_r;
  assign bus.fifo_pop       = pop_r;
  assign bus.err_out        = err_r;
  assign bus.data_out       = ser_data;
  assign bus.data_valid_out = ser_valid;
  assign bus.in_state       = in_state;
  assign bus.out_state      = out_state;

endmodule

// File: tb/tb_queue_ctrl.sv
// Testbench for queue_ctrl: directed scenarios followed by random
// commands, all checked cycle by cycle against a word-level reference
// model and a small FIFO model of the external storage.
module tb_queue_ctrl;

  localparam int W = 8;
`ifdef QUEUE_CTRL_PARITY_EN
  localparam int B = W + 1;
`else
  localparam int B = W;
`endif
  localparam int MAXC       = 4096;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  queue_ctrl_if #(.DATA_W(W)) bus ();

  queue_ctrl #(.DATA_W(W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         exp_status [MAXC];
  bit         exp_push   [MAXC];
  bit         exp_pop    [MAXC];
  bit         exp_valid  [MAXC];
  bit         exp_bit    [MAXC];
  bit         exp_err    [MAXC];
  logic [W-1:0] exp_wdata[MAXC];

  logic [W-1:0] exp_q[$];    // words the model has pushed and not yet popped
  logic [W-1:0] fifo_q[$];   // external FIFO contents (environment)
  bit           force_full = 1'b0;

  // Reference model of the input path at word level.
  int m_cnt   = 0;
  int m_word  = 0;
  bit m_ready = 1'b0;
  // First cycle in which a dequeue can be accepted again.
  int out_free = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic clear_model_from(int first);
    for (int i = first; i < MAXC; i++) begin
      exp_status[i] = 1'b0; exp_push[i]  = 1'b0; exp_pop[i] = 1'b0;
      exp_valid[i]  = 1'b0; exp_bit[i]   = 1'b0; exp_err[i] = 1'b0;
      exp_wdata[i]  = '0;
    end
  endtask

  // ---------------- driver + model, one cycle ----------------
  task automatic step(bit w, bit d, bit enq, bit deq);
    bit e;
    int word;
    int ones;
    @(negedge clock);
    cyc++;
    // outputs of this cycle
    check_eq("status_out", 32'(bus.status_out), 32'(exp_status[cyc]));
    check_eq("fifo_push", 32'(bus.fifo_push), 32'(exp_push[cyc]));
    if (exp_push[cyc])
      check_eq("fifo_wdata", 32'(bus.fifo_wdata), 32'(exp_wdata[cyc]));
    check_eq("fifo_pop", 32'(bus.fifo_pop), 32'(exp_pop[cyc]));
    check_eq("data_valid_out", 32'(bus.data_valid_out), 32'(exp_valid[cyc]));
    if (exp_valid[cyc])
      check_eq("data_out", 32'(bus.data_out), 32'(exp_bit[cyc]));
    check_eq("err_out", 32'(bus.err_out), 32'(exp_err[cyc]));

    // external FIFO reacts to this cycle's strobes
    if (bus.fifo_push) fifo_q.push_back(bus.fifo_wdata);
    if (bus.fifo_pop && fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_full  = force_full || (fifo_q.size() >= FIFO_DEPTH);

    // commands sampled at the end of this cycle
    bus.write_in   = w;
    bus.data_in    = d;
    bus.enqueue_in = enq;
    bus.dequeue_in = deq;

    // reference model: outputs of the next cycle
    e = 1'b0;
    if (!m_ready) begin
      if (enq) e = 1'b1;
      if (w) begin
        m_word = (m_word * 2 + int'(d)) % (1 << W);
        m_cnt++;
        if (m_cnt == W) m_ready = 1'b1;
      end
    end else begin
      if (w) e = 1'b1;
      if (enq) begin
        if (bus.fifo_full) e = 1'b1;
        else begin
          exp_push[cyc+1]  = 1'b1;
          exp_wdata[cyc+1] = W'(m_word);
          exp_q.push_back(W'(m_word));
          m_ready = 1'b0;
          m_cnt   = 0;
          m_word  = 0;
        end
      end
    end
    exp_status[cyc+1] = !m_ready;

    if (deq) begin
      if (cyc < out_free || bus.fifo_empty) e = 1'b1;
      else begin
        word = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
        exp_pop[cyc+1] = 1'b1;
        ones = 0;
        for (int i = 0; i < W; i++) begin
          exp_valid[cyc+3+i] = 1'b1;
          exp_bit[cyc+3+i]   = 1'((word >> (W - 1 - i)) & 1);
          ones += (word >> i) & 1;
        end
        if (B > W) begin
          exp_valid[cyc+3+W] = 1'b1;
          exp_bit[cyc+3+W]   = 1'(ones % 2);
        end
        out_free = cyc + 3 + B;
      end
    end
    exp_err[cyc+1] = e;
  endtask

  task automatic do_reset(int n);
    rst            = 1'b0;
    bus.write_in   = 1'b0;
    bus.data_in    = 1'b0;
    bus.enqueue_in = 1'b0;
    bus.dequeue_in = 1'b0;
    m_cnt = 0; m_word = 0; m_ready = 1'b0; out_free = 0;
    clear_model_from(cyc + 1);
    repeat (n) begin
      @(negedge clock);
      cyc++;
      check_eq("rst_status_out", 32'(bus.status_out), 32'd0);
      check_eq("rst_fifo_push", 32'(bus.fifo_push), 32'd0);
      check_eq("rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
      check_eq("rst_data_valid_out", 32'(bus.data_valid_out), 32'd0);
      check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
      check_eq("rst_err_out", 32'(bus.err_out), 32'd0);
    end
    rst = 1'b1;
    exp_status[cyc+1] = 1'b1;
  endtask

  task automatic write_word(logic [W-1:0] wd, int nbits);
    for (int i = 0; i < nbits; i++) step(1'b1, wd[W-1-i], 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [W-1:0] word_a = 8'hB2;
  logic [W-1:0] word_b = 8'hD3;
  logic [W-1:0] word_c = 8'h5E;

  initial begin
    bus.fifo_full  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    clear_model_from(0);
    #1;
    do_reset(2);
    idle(1);

    // assemble 1,0,1,1,0,0,1,0 and push it
    write_word(word_a, W);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check_eq("fifo_count_after_push", 32'(fifo_q.size()), 32'd1);
    if (fifo_q.size() > 0) check_eq("pushed_word", 32'(fifo_q[0]), 32'hB2);

    // pop and serialize it
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(B + 4);

    // rejected commands
    write_word(word_b, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);          // enqueue with partial word
    step(1'b0, 1'b0, 1'b0, 1'b1);          // dequeue on empty FIFO
    step(1'b0, 1'b0, 1'b1, 1'b1);          // both rejected together
    idle(1);
    for (int i = 3; i < W; i++) step(1'b1, word_b[W-1-i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);          // write_in in WORD_READY
    force_full = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);          // enqueue into full FIFO
    force_full = 1'b0;
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);          // retry pushes the same word
    idle(2);

    // concurrency: enqueue+dequeue while a previous word is shifting
    write_word(word_c, W);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b0);
    idle(B + 2);

    // reset in the middle of a burst
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(bus.data_valid_out), 32'd0);
    check_eq("async_rst_status", 32'(bus.status_out), 32'd0);
    do_reset(2);
    idle(B + 4);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      force_full = ($urandom_range(0, 99) < 10);
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 12));
    end
    force_full = 1'b0;
    idle(B + 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
Sequencing controller for the serial-in/serial-out word queue behind the TOP-level serial pins. Assembles DATA_W serial bits into a word, pushes the word into an external synchronous FIFO on an enqueue command, and pops and re-serializes words on a dequeue command. The input path and the output path are independent FSMs sharing one clock domain. The block sits between the TOP pins and the FIFO storage.

Parameters:
DATA_W, 8, word width in bits; also the number of serial bits per word.
CNT_W, $clog2(DATA_W+1), bit-counter width; derived, not overridden.

Ports:
clock  in  1  system clock (1 MHz)
rst  in  1  reset; asynchronous, active-low
data_in  in  1  serial input bit, sampled when write_in=1
write_in  in  1  bit strobe, 1-cycle pulse
enqueue_in  in  1  push command, 1-cycle pulse
dequeue_in  in  1  pop command, 1-cycle pulse
status_out  out  1  1 = ready to accept a serial bit
data_out  out  1  serial output bit
data_valid_out  out  1  data_out is valid this cycle
err_out  out  1  1-cycle pulse on a rejected command
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_push  out  1  FIFO write strobe
fifo_wdata  out  DATA_W  FIFO write data
fifo_pop  out  1  FIFO read strobe
fifo_rdata  in  DATA_W  FIFO read data, valid 1 cycle after fifo_pop

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - all outputs to 0, both FSMs to their initial state, the shift register and the bit counter.
  - A partially assembled or partially shifted word is discarded; no push/pop is emitted during or after reset.
- Input FSM states: COLLECT, WORD_READY.
  - status_out = (state==COLLECT), registered.
  - COLLECT + write_in: shift data_in into the LSB, shifting left (first bit received ends up as MSB); counter increments.
  - When the counter reaches DATA_W, go to WORD_READY next cycle; status_out falls in that same cycle.
  - write_in outside COLLECT: bit ignored, err_out=1.
  - WORD_READY + enqueue_in + !fifo_full: fifo_push=1 for exactly 1 cycle with fifo_wdata=word; counter cleared; return to COLLECT; status_out=1 the cycle after the push.
  - WORD_READY + enqueue_in + fifo_full: no push, word held, err_out=1.
  - enqueue_in in COLLECT (incomplete word): ignored, err_out=1; partial word retained.
- Output FSM states: IDLE, POP, LOAD, SHIFT.
  - IDLE + dequeue_in + !fifo_empty: go to POP, assert fifo_pop for 1 cycle.
  - LOAD: capture fifo_rdata into the output shift register.
  - SHIFT: emit DATA_W bits MSB-first, one per cycle, with data_valid_out=1; return to IDLE after the last bit.
  - First valid bit appears 3 cycles after the dequeue_in cycle.
  - dequeue_in with fifo_empty, or while not IDLE: ignored, err_out=1.
- Simultaneous events:
  - enqueue_in and dequeue_in in the same cycle are both serviced.
  - write_in during SHIFT is accepted normally.
  - If both paths reject in one cycle, err_out is still a single 1-cycle pulse.
- fifo_push and fifo_pop never assert while rst=0.

Optional Feature:
QUEUE_CTRL_PARITY_EN
- Defined: after the DATA_W data bits, SHIFT emits one extra even-parity bit (XOR of the word) with data_valid_out=1, giving a DATA_W+1 cycle burst.
- Undefined: the burst is exactly DATA_W cycles and no parity logic is generated.

Decomposition:
- Package queue_ctrl_pkg holds:
  - in_state_t enum {COLLECT, WORD_READY}
  - out_state_t enum {IDLE, POP, LOAD, SHIFT}
  - the default DATA_W constant
- The natural sub-module is queue_serializer: parallel load, MSB-first shift, bit counter, and the optional parity bit. It exposes load, busy, data_out and data_valid_out.

Test Plan:
- Reset clears state: rst low, then high after 2 cycles -> status_out=1, all other outputs 0. Drive rst low during SHIFT -> data_valid_out=0 immediately; no fifo_pop afterwards.
- Assemble and push one word: write bits 1,0,1,1,0,0,1,0, then enqueue_in -> status_out falls after the 8th bit; one-cycle fifo_push with fifo_wdata=8'hB2; status_out=1 on the following cycle.
- Pop and serialize: FIFO model holds 8'hB2, pulse dequeue_in -> fifo_pop 1 cycle later; data_valid_out high for 8 cycles with data_out sequence 1,0,1,1,0,0,1,0 starting 3 cycles after dequeue_in. With the parity macro defined: a 9th bit of 0.
- Rejected commands:
  - enqueue_in after 3 bits -> err_out pulse, no push.
  - dequeue_in with fifo_empty=1 -> err_out pulse, no pop.
  - write_in in WORD_READY -> err_out pulse, word unchanged.
- Full FIFO: word ready, fifo_full=1, enqueue_in -> err_out pulse, no push. Then fifo_full=0 and enqueue_in -> push of the same word.
- Concurrency: enqueue_in and dequeue_in in the same cycle during SHIFT of a previous word -> push occurs; dequeue is rejected with err_out; the serial stream is not disturbed.
